// File: rtl/clock_pkg.sv
// Shared definitions for the board's button front ends: the press/hold/repeat
// state encoding and default timing constants for the board clock rate.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 50;
  localparam int DEF_REPEAT_CYCLES   = 10;
  localparam int DEF_CNT_W           = 32;

  localparam logic [1:0] EV_NONE    = 2'd0;
  localparam logic [1:0] EV_PRESS   = 2'd1;
  localparam logic [1:0] EV_RPT     = 2'd2;
  localparam logic [1:0] EV_RELEASE = 2'd3;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter. The debounced level only
// changes after DEBOUNCE_CYCLES consecutive samples disagree with it.
module button_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s0;
  logic             s1;
  logic [CNT_W-1:0] cnt;
  logic             change;

  // rise/fall are combinational strobes for the edge on which level flips,
  // so a downstream register can pulse on the same edge as level.
  assign change = (s1 != level) && (cnt == DB_LAST);
  assign rise   = change && s1;
  assign fall   = change && !s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= btn_in;
      s1 <= s0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (s1 == level) begin
      cnt <= '0;
    end else if (change) begin
      level <= s1;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_repeat_pulser.sv
// Button front end: debounced level plus single-cycle press, auto-repeat and
// release pulses for the alarm-clock control FSM.
module button_repeat_pulser
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic held,
  output logic press,
  output logic rpt,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             db_rise;
  logic             db_fall;
  btn_state_t       state;
  btn_state_t       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             press_d;
  logic             rpt_d;
  logic             release_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .level (held),
    .rise  (db_rise),
    .fall  (db_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      rpt           <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      press         <= press_d;
      rpt           <= rpt_d;
      release_pulse <= release_d;
    end
  end

  // A debounced fall is checked before the terminal count so that a release
  // landing on a repeat instant suppresses that repeat.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    press_d   = 1'b0;
    rpt_d     = 1'b0;
    release_d = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (db_rise) begin
          press_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (db_fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (cnt == HOLD_LAST) begin
          rpt_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (db_fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (cnt == REPEAT_LAST) begin
          rpt_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
